// File: rtl/sc_stream_decoder.sv
// rtl/sc_stream_decoder.sv - stochastic bitstream to binary decoder with valid/ready result
module sc_stream_decoder #(
    parameter int CNT_W   = 7,
    parameter bit BIPOLAR = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             bit_valid_i,
    input  logic             bit_in_i,
    output logic             busy_o,
    output logic [CNT_W+1:0] result_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic             drop_o
);

    // Window length N = 2^CNT_W, in the result container width.
    localparam logic [CNT_W+1:0] N_EXT    = {2'b01, {CNT_W{1'b0}}};
    // len_q value while the final bit of the window is pending.
    localparam logic [CNT_W-1:0] LEN_LAST = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W:0]   ones_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W+1:0] result_q;
    logic             busy_q;
    logic             result_valid_q;
    logic             drop_q;

    logic [CNT_W:0]   ones_d;
    logic [CNT_W+1:0] result_d;

    // Running count including the current bit, and its mapping to the output code.
    always_comb begin
        ones_d   = ones_q + {{CNT_W{1'b0}}, bit_in_i};
        result_d = {1'b0, ones_d};
        if (BIPOLAR) begin
            result_d = {ones_d, 1'b0} - N_EXT;
        end
    end

    // Window control FSM: counters, captured result, registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            ones_q         <= '0;
            len_q          <= '0;
            result_q       <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            drop_q         <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        ones_q  <= '0;
                        len_q   <= '0;
                        drop_q  <= 1'b0;
                        state_q <= ST_ACCUM;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (start_i) begin
                        // Restart wins over a bit offered in the same cycle.
                        ones_q <= '0;
                        len_q  <= '0;
                        drop_q <= 1'b0;
                    end else if (bit_valid_i) begin
                        if (len_q == LEN_LAST) begin
                            result_q       <= result_d;
                            state_q        <= ST_HOLD;
                            busy_q         <= 1'b0;
                            result_valid_q <= 1'b1;
                        end else begin
                            ones_q <= ones_d;
                            len_q  <= len_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // A start without the handshake is ignored so the result is never lost.
                    if (result_ready_i) begin
                        result_valid_q <= 1'b0;
                        if (start_i) begin
                            ones_q  <= '0;
                            len_q   <= '0;
                            drop_q  <= 1'b0;
                            state_q <= ST_ACCUM;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    busy_q         <= 1'b0;
                    result_valid_q <= 1'b0;
                end
            endcase
            // Bits offered outside a window are lost; flag it after any start clear.
            if (bit_valid_i && (state_q != ST_ACCUM)) begin
                drop_q <= 1'b1;
            end
        end
    end

    assign busy_o         = busy_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign drop_o         = drop_q;

endmodule
